// File: rtl/cr_fifo_pop_stream_if.sv
// Handshake bundle between the FIFO read port, the pop-side adapter and its stream consumer.
// master = adapter side, slave = FIFO/consumer side.
interface cr_fifo_pop_stream_if #(
  parameter int pWidth = 8
);
  logic              PopReq_n;
  logic              PopEmpty;
  logic [pWidth-1:0] PopFifoData;
  logic              OutValid;
  logic              OutReady;
  logic [pWidth-1:0] OutData;
  logic [1:0]        BufCount;

  modport master (
    output PopReq_n,
    input  PopEmpty,
    input  PopFifoData,
    output OutValid,
    input  OutReady,
    output OutData,
    output BufCount
  );

  modport slave (
    input  PopReq_n,
    output PopEmpty,
    output PopFifoData,
    input  OutValid,
    output OutReady,
    input  OutData,
    input  BufCount
  );
endinterface

// File: rtl/cr_fifo_pop_stream.sv
// Pop-side FIFO adapter: issues pops only when the 2-entry skid buffer has room for the
// word, so one word per cycle flows through despite the RAM read latency.
module cr_fifo_pop_stream #(
  parameter int pWidth     = 8,
  parameter int pAsyncRead = 0
) (
  input  logic                        Pop_clk,
  input  logic                        Pop_rst_n,
  input  logic                        Flush,
  input  logic                        Enable,
  cr_fifo_pop_stream_if.master        bus
);

  localparam bit cFallthrough = (pAsyncRead != 0);

  logic [pWidth-1:0] r_entry [2];
  logic [1:0]        r_count;
  logic              r_inflight;

  logic              w_deq;
  logic              w_issue;
  logic              w_cap;
  logic [2:0]        w_occ;
  logic [pWidth-1:0] w_word;

  assign w_deq  = (r_count != 2'd0) & bus.OutReady;
  // Occupancy after this cycle's dequeue; a new pop is allowed only if it leaves a free slot.
  assign w_occ  = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_deq};
  assign w_issue = Pop_rst_n & ~Flush & Enable & ~bus.PopEmpty & (w_occ < 3'd2);
  assign w_word = bus.PopFifoData;

  generate
    if (cFallthrough) begin : g_fallthrough
      assign w_cap = w_issue;
    end else begin : g_registered
      assign w_cap = r_inflight;
    end
  endgenerate

  always_ff @(posedge Pop_clk) begin
    if (!Pop_rst_n) begin
      r_entry[0] <= '0;
      r_entry[1] <= '0;
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else if (Flush) begin
      // Entries keep stale data; OutData is don't-care while OutValid is low.
      r_count    <= 2'd0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue & ~cFallthrough;
      case ({w_cap, w_deq})
        2'b01: begin
          r_entry[0] <= r_entry[1];
          r_count    <= r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_entry[0] <= w_word;
          end else begin
            r_entry[1] <= w_word;
          end
          r_count <= r_count + 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_entry[0] <= w_word;
          end else begin
            r_entry[0] <= r_entry[1];
            r_entry[1] <= w_word;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.PopReq_n = ~w_issue;
  assign bus.OutValid = (r_count != 2'd0);
  assign bus.OutData  = r_entry[0];
  assign bus.BufCount = r_count;

endmodule

// File: tb/tb_cr_fifo_pop_stream.sv
// Bench for cr_fifo_pop_stream: registered-read and fallthrough instances share one stimulus;
// each has a FIFO model and a queue scoreboard of popped-but-undelivered words.
module tb_cr_fifo_pop_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic flush;
  logic enable;
  logic out_ready;

  logic [7:0] fifo_mem [1024];
  int         wr_ptr = 0;

  int n_chk = 0;
  int n_bad = 0;

  logic [1:0] v_valid;
  logic [1:0] v_popreq_n;
  logic [1:0] v_empty;
  logic [7:0] v_data [2];
  logic [1:0] v_cnt [2];
  int         v_deliv [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s t=%0t got=0x%0h want=0x%0h", tag, $time, got, want);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    cr_fifo_pop_stream_if #(.pWidth(8)) bus ();

    int         rd_ptr = 0;
    logic [7:0] rd_data_q = 8'h00;
    logic [7:0] sb [$];
    int         deliv = 0;
    logic       hold = 1'b0;
    logic [7:0] held = 8'h00;
    logic       popped_last = 1'b0;
    int         exp_cnt;

    cr_fifo_pop_stream #(.pWidth(8), .pAsyncRead(gi)) u_dut (
      .Pop_clk   (clk),
      .Pop_rst_n (rst_n),
      .Flush     (flush),
      .Enable    (enable),
      .bus       (bus)
    );

    // FIFO model: registered read for channel 0, fallthrough for channel 1.
    assign bus.PopEmpty    = (rd_ptr == wr_ptr);
    assign bus.PopFifoData = (gi == 1) ? fifo_mem[rd_ptr[9:0]] : rd_data_q;
    assign bus.OutReady    = out_ready;

    assign v_valid[gi]    = bus.OutValid;
    assign v_popreq_n[gi] = bus.PopReq_n;
    assign v_empty[gi]    = bus.PopEmpty;
    assign v_data[gi]     = bus.OutData;
    assign v_cnt[gi]      = bus.BufCount;
    assign v_deliv[gi]    = deliv;

    always @(posedge clk) begin
      if (!bus.PopReq_n) begin
        rd_data_q <= fifo_mem[rd_ptr[9:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end

    initial begin
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          check($sformatf("ch%0d_rst_popreq", gi), 32'(bus.PopReq_n), 32'd1);
          sb.delete();
          hold        = 1'b0;
          popped_last = 1'b0;
        end else begin
          // A word popped at the previous edge is still in the RAM pipe on the registered channel.
          exp_cnt = sb.size() - (((gi == 0) && popped_last) ? 1 : 0);
          check($sformatf("ch%0d_occupancy", gi), 32'(sb.size() <= 2), 32'd1);
          check($sformatf("ch%0d_bufcount", gi), 32'(bus.BufCount), 32'(exp_cnt));
          check($sformatf("ch%0d_valid", gi), 32'(bus.OutValid), 32'(exp_cnt != 0));
          check($sformatf("ch%0d_underrun", gi), 32'(!bus.PopReq_n && bus.PopEmpty), 32'd0);
          if (hold) begin
            check($sformatf("ch%0d_hold_valid", gi), 32'(bus.OutValid), 32'd1);
            check($sformatf("ch%0d_hold_data", gi), 32'(bus.OutData), 32'(held));
          end
          if (bus.OutValid && out_ready && sb.size() != 0) begin
            check($sformatf("ch%0d_data", gi), 32'(bus.OutData), 32'(sb[0]));
            $display("ch%0d t=%0t deliver 0x%02h", gi, $time, bus.OutData);
            void'(sb.pop_front());
            deliv++;
          end
          hold = bus.OutValid & ~out_ready & ~flush;
          held = bus.OutData;
          if (flush) sb.delete();
          popped_last = !bus.PopReq_n;
          if (!bus.PopReq_n) sb.push_back(fifo_mem[rd_ptr[9:0]]);
        end
      end
    end
  end

  int   o_npop [2];
  int   o_fpop [2];
  int   o_lpop [2];
  int   o_nval [2];
  int   o_fval [2];
  int   o_lval [2];
  int   d0 [2];
  logic got_c [2];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w);
    fifo_mem[wr_ptr[9:0]] = w;
    wr_ptr++;
  endtask

  task automatic observe(input int n);
    for (int c = 0; c < 2; c++) begin
      o_npop[c] = 0; o_fpop[c] = -1; o_lpop[c] = -1;
      o_nval[c] = 0; o_fval[c] = -1; o_lval[c] = -1;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (!v_popreq_n[c]) begin
          if (o_npop[c] == 0) o_fpop[c] = i;
          o_lpop[c] = i;
          o_npop[c]++;
        end
        if (v_valid[c]) begin
          if (o_nval[c] == 0) o_fval[c] = i;
          o_lval[c] = i;
          o_nval[c]++;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; enable = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) fifo_mem[i] = 8'h00;
    step();
    step();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_reset_valid", c), 32'(v_valid[c]), 32'd0);
      check($sformatf("ch%0d_reset_data", c), 32'(v_data[c]), 32'd0);
      check($sformatf("ch%0d_reset_cnt", c), 32'(v_cnt[c]), 32'd0);
      check($sformatf("ch%0d_reset_popreq", c), 32'(v_popreq_n[c]), 32'd1);
    end

    // Three preloaded words, consumer always ready.
    step(); rst_n = 1'b1;
    step();
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    out_ready = 1'b1; enable = 1'b1;
    observe(8);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_t1_npop", c), 32'(o_npop[c]), 32'd3);
      check($sformatf("ch%0d_t1_first_pop", c), 32'(o_fpop[c]), 32'd0);
      check($sformatf("ch%0d_t1_pop_run", c), 32'(o_lpop[c] - o_fpop[c]), 32'd2);
      check($sformatf("ch%0d_t1_nval", c), 32'(o_nval[c]), 32'd3);
      check($sformatf("ch%0d_t1_val_run", c), 32'(o_lval[c] - o_fval[c]), 32'd2);
      check($sformatf("ch%0d_t1_latency", c), 32'(o_fval[c] - o_fpop[c]), (c == 0) ? 32'd2 : 32'd1);
    end

    // Consumer stalled: only two pops fit, then the rest stream without a bubble.
    step(); out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(8'h40 + 8'(i));
    observe(6);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_t2_npop", c), 32'(o_npop[c]), 32'd2);
      check($sformatf("ch%0d_t2_cnt", c), 32'(v_cnt[c]), 32'd2);
      check($sformatf("ch%0d_t2_popreq", c), 32'(v_popreq_n[c]), 32'd1);
    end
    step(); out_ready = 1'b1;
    observe(8);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_t2_nval", c), 32'(o_nval[c]), 32'd5);
      check($sformatf("ch%0d_t2_first_val", c), 32'(o_fval[c]), 32'd0);
      check($sformatf("ch%0d_t2_val_run", c), 32'(o_lval[c]), 32'd4);
    end

    // Sixteen random words, consumer ready on alternate cycles.
    step();
    for (int c = 0; c < 2; c++) d0[c] = v_deliv[c];
    for (int i = 0; i < 16; i++) push_word(8'($urandom));
    for (int i = 0; i < 40; i++) begin
      step();
      out_ready = (i % 2 == 0);
    end
    out_ready = 1'b1;
    repeat (4) step();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_t3_delivered", c), 32'(v_deliv[c] - d0[c]), 32'd16);
      check($sformatf("ch%0d_t3_drained", c), 32'(v_empty[c]), 32'd1);
    end

    // Flush right after a pop issue with one word buffered.
    step(); out_ready = 1'b0; push_word(8'hA1);
    step(); step(); step();
    @(negedge clk);
    for (int c = 0; c < 2; c++) check($sformatf("ch%0d_t4_cnt1", c), 32'(v_cnt[c]), 32'd1);
    step(); push_word(8'hB2); push_word(8'hC3);
    @(negedge clk);
    for (int c = 0; c < 2; c++) check($sformatf("ch%0d_t4_issue", c), 32'(v_popreq_n[c]), 32'd0);
    step(); flush = 1'b1;
    step(); flush = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_t4_valid", c), 32'(v_valid[c]), 32'd0);
      check($sformatf("ch%0d_t4_cnt0", c), 32'(v_cnt[c]), 32'd0);
      got_c[c] = 1'b0;
    end
    step(); out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (!got_c[c] && v_valid[c]) begin
          got_c[c] = 1'b1;
          check($sformatf("ch%0d_t4_next_word", c), 32'(v_data[c]), 32'hC3);
        end
      end
    end
    for (int c = 0; c < 2; c++) check($sformatf("ch%0d_t4_timeout", c), 32'(got_c[c]), 32'd1);

    // One-cycle reset in the middle of a stream.
    step();
    for (int i = 0; i < 10; i++) push_word(8'h60 + 8'(i));
    repeat (4) step();
    rst_n = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 2; c++) check($sformatf("ch%0d_t5_popreq", c), 32'(v_popreq_n[c]), 32'd1);
    step(); rst_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_t5_valid", c), 32'(v_valid[c]), 32'd0);
      check($sformatf("ch%0d_t5_data", c), 32'(v_data[c]), 32'd0);
      check($sformatf("ch%0d_t5_cnt", c), 32'(v_cnt[c]), 32'd0);
    end
    repeat (16) step();
    @(negedge clk);
    for (int c = 0; c < 2; c++) check($sformatf("ch%0d_t5_drained", c), 32'(v_empty[c]), 32'd1);

    // Full-rate streaming of twelve words.
    step();
    for (int i = 0; i < 12; i++) push_word(8'($urandom));
    observe(16);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_t6_nval", c), 32'(o_nval[c]), 32'd12);
      check($sformatf("ch%0d_t6_val_run", c), 32'(o_lval[c] - o_fval[c]), 32'd11);
      check($sformatf("ch%0d_t6_latency", c), 32'(o_fval[c] - o_fpop[c]), (c == 0) ? 32'd2 : 32'd1);
    end

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 800; i++) begin
      step();
      enable    = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 2) == 0 && wr_ptr < 1000) push_word(8'($urandom));
    end
    step();
    rst_n = 1'b1; flush = 1'b0; enable = 1'b1; out_ready = 1'b1;
    repeat (40) step();
    @(negedge clk);
    for (int c = 0; c < 2; c++) begin
      check($sformatf("ch%0d_rand_drained", c), 32'(v_empty[c]), 32'd1);
      check($sformatf("ch%0d_rand_idle", c), 32'(v_valid[c]), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
